// File: rtl/hm_step_tracker.sv
// Step counter with a one-second activity tracker. Raw sensor pulses are synchronised and
// edge-detected; total steps and active seconds are kept as saturating 4-digit BCD counts.
module hm_step_tracker #(
    parameter int CLK_HZ     = 100000000,
    parameter int ACT_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic       clr,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] d4,
    output logic [3:0] d5,
    output logic [3:0] d6,
    output logic [3:0] d7,
    output logic       step_sat,
    output logic       sec_tick
);

    localparam int              TB_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TB_W-1:0] TB_LAST = TB_W'(CLK_HZ - 1);
    localparam logic [TB_W-1:0] TB_ONE  = TB_W'(1);
    localparam logic [8:0]      THRESH  = 9'(ACT_THRESH);
    localparam logic [15:0]     BCD_MAX = 16'h9999;

    logic            sync1, sync2, sync3;
    logic            fill1, fill2;
    logic            armed;
    logic            step_evt;

    logic [15:0]     steps_q, steps_nxt;
    logic [15:0]     act_q, act_nxt;
    logic [7:0]      win_cnt, win_nxt;
    logic [8:0]      win_tot;
    logic [TB_W-1:0] tb_cnt, tb_nxt;

    // Saturating 4-digit BCD increment; 9999 is held rather than wrapped.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != BCD_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // fill2 marks sync2 as holding a real sample; armed needs a genuine low before any rise
    // counts, so a pulse already high when reset releases is not taken as a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= pulse;
            sync2 <= sync1;
            sync3 <= sync2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            armed <= armed | (fill2 & ~sync2);
        end
    end

    assign step_evt = sync2 & ~sync3 & armed;

    always_comb begin
        tb_nxt    = (tb_cnt == TB_LAST) ? '0 : tb_cnt + TB_ONE;
        win_tot   = {1'b0, win_cnt} + {8'd0, step_evt};
        steps_nxt = step_evt ? bcd_inc(steps_q) : steps_q;
        act_nxt   = act_q;
        win_nxt   = win_cnt;
        // A step landing in the tick cycle is credited to the window that is closing.
        if (sec_tick) begin
            win_nxt = '0;
            if (win_tot >= THRESH) begin
                act_nxt = bcd_inc(act_q);
            end
        end else if (step_evt && (win_cnt != 8'hFF)) begin
            win_nxt = win_cnt + 8'd1;
        end
    end

    // sec_tick is registered from the next timebase value so it is high while tb_cnt == CLK_HZ-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            steps_q  <= '0;
            act_q    <= '0;
            win_cnt  <= '0;
            tb_cnt   <= '0;
            step_sat <= 1'b0;
            sec_tick <= 1'b0;
        end else if (clr) begin
            steps_q  <= '0;
            act_q    <= '0;
            win_cnt  <= '0;
            tb_cnt   <= '0;
            step_sat <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            steps_q  <= steps_nxt;
            act_q    <= act_nxt;
            win_cnt  <= win_nxt;
            tb_cnt   <= tb_nxt;
            step_sat <= step_sat | (steps_nxt == BCD_MAX);
            sec_tick <= (tb_nxt == TB_LAST);
        end
    end

    assign {d3, d2, d1, d0} = steps_q;
    assign {d7, d6, d5, d4} = act_q;

endmodule

// File: tb/tb_hm_step_tracker.sv
// Directed bench for hm_step_tracker: a cycle model tracks timing while a queue of step
// counts predicted at drive time is checked when each step lands.
module tb_hm_step_tracker;

    localparam int CLK_HZ     = 10;
    localparam int ACT_THRESH = 2;

    logic       clk, rst, pulse, clr;
    logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       step_sat, sec_tick;

    int checks, errors;

    logic [15:0] exp_q[$];
    int exp_steps, cur_steps, m_act, m_win, m_tb, vc;
    bit m_sat, h1, h2, h3;

    hm_step_tracker #(.CLK_HZ(CLK_HZ), .ACT_THRESH(ACT_THRESH)) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .clr(clr),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .step_sat(step_sat), .sec_tick(sec_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check("steps", {d3, d2, d1, d0}, to_bcd(cur_steps));
        check("active", {d7, d6, d5, d4}, to_bcd(m_act));
        check("sec_tick", 16'(sec_tick), 16'(m_tb == CLK_HZ - 1));
        check("step_sat", 16'(step_sat), 16'(m_sat));
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_steps = 0;
        cur_steps = 0;
        m_act     = 0;
        m_win     = 0;
        m_tb      = 0;
        m_sat     = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        h1 = 1'b0;
        h2 = 1'b0;
        h3 = 1'b0;
        vc = 0;
    endtask

    // driver: predicted total for a step about to be driven
    task automatic push_step();
        exp_steps = (exp_steps < 9999) ? exp_steps + 1 : 9999;
        exp_q.push_back(16'(exp_steps));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic cyc(input logic p, input logic c);
        bit evt, tck, landed;
        pulse  = p;
        clr    = c;
        landed = 1'b0;
        @(posedge clk);
        evt = h2 && !h3 && (vc >= 3);
        tck = (m_tb == CLK_HZ - 1);
        h3  = h2;
        h2  = h1;
        h1  = p;
        if (vc < 3) vc++;
        if (c) begin
            model_clear();
        end else begin
            if (evt && exp_q.size() > 0) begin
                cur_steps = int'(exp_q.pop_front());
                landed    = 1'b1;
            end
            if (tck) begin
                if ((m_win + int'(evt) >= ACT_THRESH) && (m_act < 9999)) m_act++;
                m_win = 0;
            end else if (evt && m_win < 255) begin
                m_win++;
            end
            if (cur_steps == 9999) m_sat = 1'b1;
            m_tb = tck ? 0 : m_tb + 1;
        end
        #1;
        if (landed) check("step_landing", {d3, d2, d1, d0}, to_bcd(cur_steps));
        check_outputs();
    endtask

    task automatic do_step(input int hi, input int lo);
        push_step();
        repeat (hi) cyc(1'b1, 1'b0);
        repeat (lo) cyc(1'b0, 1'b0);
    endtask

    initial begin
        int  n, act0;
        bit  seen, p;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        pulse  = 1'b0;
        clr    = 1'b0;
        model_reset();
        #12;
        check("reset_steps", {d3, d2, d1, d0}, 16'h0000);
        check("reset_active", {d7, d6, d5, d4}, 16'h0000);
        check("reset_tick", 16'(sec_tick), 16'd0);
        check("reset_sat", 16'(step_sat), 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // First step latency, then pulse held high and a falling edge.
        repeat (3) cyc(1'b0, 1'b0);
        push_step();
        cyc(1'b1, 1'b0);
        check("lat_edge1", 16'(d0), 16'd0);
        cyc(1'b1, 1'b0);
        check("lat_edge2", 16'(d0), 16'd0);
        cyc(1'b1, 1'b0);
        check("lat_edge3", 16'(d0), 16'd1);
        repeat (6) cyc(1'b1, 1'b0);
        check("held_high", {d3, d2, d1, d0}, 16'h0001);
        repeat (3) cyc(1'b0, 1'b0);
        check("fall_no_step", {d3, d2, d1, d0}, 16'h0001);
        check("act_one_step", {d7, d6, d5, d4}, 16'h0000);

        // One step in window 1, two in window 2 with the second landing in the tick cycle.
        cyc(1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            p = (k == 2) || (k == 12) || (k == 18);
            if (p) push_step();
            cyc(p, 1'b0);
            if (k == 10) check("act_win1", {d7, d6, d5, d4}, 16'h0000);
            if (k == 19) check("win_before_tick", 16'(dut.win_cnt), 16'd1);
            if (k == 20) begin
                check("act_win2", {d7, d6, d5, d4}, 16'h0001);
                check("win_reload", 16'(dut.win_cnt), 16'd0);
                check("steps_win2", {d3, d2, d1, d0}, 16'h0003);
            end
        end

        // clr collides with a step landing and a sec_tick at 0042.
        repeat (39) do_step(1, 1);
        cyc(1'b0, 1'b0);
        n = 0;
        while (m_tb != 7 && n < 20) begin
            cyc(1'b0, 1'b0);
            n++;
        end
        check("pre_clr_steps", {d3, d2, d1, d0}, 16'h0042);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("tick_before_clr", 16'(sec_tick), 16'd1);
        cyc(1'b0, 1'b1);
        check("clr_steps", {d3, d2, d1, d0}, 16'h0000);
        check("clr_active", {d7, d6, d5, d4}, 16'h0000);
        check("clr_sat", 16'(step_sat), 16'd0);
        check("clr_win", 16'(dut.win_cnt), 16'd0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            cyc(1'b0, 1'b0);
            n++;
            if (sec_tick) seen = 1'b1;
        end
        check("tick_after_clr", 16'(n), 16'd9);

        // Carry 0999 -> 1000, then saturation at 9999.
        repeat (999) do_step(1, 1);
        cyc(1'b0, 1'b0);
        check("preload_0999", {d3, d2, d1, d0}, 16'h0999);
        do_step(1, 1);
        cyc(1'b0, 1'b0);
        check("carry_1000", {d3, d2, d1, d0}, 16'h1000);
        check("sat_low_1000", 16'(step_sat), 16'd0);
        repeat (8999) do_step(1, 1);
        cyc(1'b0, 1'b0);
        check("reach_9999", {d3, d2, d1, d0}, 16'h9999);
        check("sat_set", 16'(step_sat), 16'd1);
        repeat (3) do_step(1, 1);
        cyc(1'b0, 1'b0);
        check("sat_hold", {d3, d2, d1, d0}, 16'h9999);
        check("sat_sticky", 16'(step_sat), 16'd1);
        act0 = m_act;
        repeat (15) do_step(1, 1);
        check("act_after_sat", {d7, d6, d5, d4}, to_bcd(act0 + 3));

        // Build 0123 / 0004, then async reset mid-window with pulse held high.
        cyc(1'b0, 1'b1);
        for (int w = 0; w < 119; w++) begin
            for (int k = 0; k < 10; k++) begin
                p = (k == 2) || ((w >= 115) && (k == 5));
                if (p) push_step();
                cyc(p, 1'b0);
            end
        end
        check("pre_rst_steps", {d3, d2, d1, d0}, 16'h0123);
        check("pre_rst_active", {d7, d6, d5, d4}, 16'h0004);
        repeat (4) cyc(1'b0, 1'b0);
        #3;
        rst   = 1'b0;
        pulse = 1'b1;
        #1;
        model_reset();
        check("rst_async_steps", {d3, d2, d1, d0}, 16'h0000);
        check("rst_async_active", {d7, d6, d5, d4}, 16'h0000);
        check("rst_async_win", 16'(dut.win_cnt), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_steps", {d3, d2, d1, d0}, 16'h0000);
        check("rst_held_tick", 16'(sec_tick), 16'd0);
        @(negedge clk);
        rst  = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            cyc(1'b1, 1'b0);
            n++;
            if (sec_tick) seen = 1'b1;
        end
        check("first_tick_after_rst", 16'(n), 16'd9);
        repeat (5) cyc(1'b1, 1'b0);
        check("no_step_on_release", {d3, d2, d1, d0}, 16'h0000);
        repeat (2) cyc(1'b0, 1'b0);
        do_step(1, 3);
        check("step_after_release", {d3, d2, d1, d0}, 16'h0001);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
